// File: rtl/fp_normalize_left.sv
// rtl/fp_normalize_left.sv - sequential post-add left normalizer with carry, zero, overflow and underflow handling
module fp_normalize_left #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_carry,
  input  logic [MW-1:0] in_mant,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic [7:0]    out_shamt,
  output logic          out_zero,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [EW-1:0] EXP_MAX = {EW{1'b1}};
  localparam logic [EW-1:0] EXP_ONE = EW'(1);

  state_t        state;
  state_t        state_next;
  logic [EW-1:0] exp_inc;
  logic          in_special;

  // Exponent after a carry right-shift; in_exp==all-ones is filtered out first, so this never wraps.
  assign exp_inc = in_exp + EXP_ONE;

  // Operands that finish without any SHIFT cycle: inf/NaN, carry, zero, already normalized or exp<=1.
  assign in_special = (in_exp == EXP_MAX) || in_carry || (in_mant == '0) ||
                      in_mant[MW-1] || (in_exp == '0) || (in_exp == EXP_ONE);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_next = in_special ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // Stop on underflow to subnormal, or when this shift moves a one into the hidden bit.
        if ((out_exp == EXP_ONE) || out_mant[MW-2]) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture and classify in IDLE, shift one bit per SHIFT cycle, hold in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mant  <= '0;
      out_exp   <= '0;
      out_shamt <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out_shamt <= '0;
            out_zero  <= 1'b0;
            out_ovf   <= 1'b0;
            out_mant  <= in_mant;
            out_exp   <= in_exp;
            if (in_exp == EXP_MAX) begin
              // inf/NaN passes through untouched
            end else if (in_carry) begin
              if (exp_inc == EXP_MAX) begin
                out_mant <= '0;
                out_exp  <= EXP_MAX;
                out_ovf  <= 1'b1;
              end else begin
                out_mant <= {1'b1, in_mant[MW-1:1]};
                out_exp  <= exp_inc;
              end
            end else if (in_mant == '0) begin
              out_exp  <= '0;
              out_zero <= 1'b1;
            end else if (in_mant[MW-1] || (in_exp == '0)) begin
              // already normalized, or already subnormal
            end else if (in_exp == EXP_ONE) begin
              out_exp <= '0;
            end
          end
        end
        SHIFT: begin
          if (out_exp == EXP_ONE) begin
            out_exp <= '0;
          end else begin
            out_mant  <= {out_mant[MW-2:0], 1'b0};
            out_exp   <= out_exp - EXP_ONE;
            out_shamt <= out_shamt + 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/fp_normalize_left.md
Name: fp_normalize_left

Overview:
- Sequential post-add normalizer for the single-precision FP datapath.
- Counterpart of the mantissa-alignment right shifter. The aligner shifts the smaller operand right before the add; this block shifts the raw sum left, one bit per cycle, until the hidden bit (bit 23) is set, decrementing the exponent per shift.
- Also handles adder carry-out (one right shift, exponent +1), zero results, exponent overflow to infinity and underflow to subnormal.
- Valid/ready on both sides; one operation in flight.

Parameters:
MW, 24, mantissa width including hidden bit
EW, 8, biased exponent width (all-ones = inf/NaN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input operand valid
in_ready  out  1  block can accept (high only in IDLE)
in_carry  in  1  adder carry-out above bit MW-1
in_mant  in  MW  raw adder sum bits [MW-1:0]
in_exp  in  EW  biased exponent of the aligned operands
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_mant  out  MW  normalized mantissa
out_exp  out  EW  adjusted biased exponent
out_shamt  out  8  total left shifts applied
out_zero  out  1  result is exact zero
out_ovf  out  1  exponent overflowed to infinity

Behaviour:
- Reset (async, active-high): state=IDLE; out_mant, out_exp, out_shamt=0; out_zero, out_ovf, out_valid=0; in_ready=1. Reset mid-SHIFT or mid-DONE aborts immediately; the held result is discarded.
- States are IDLE, SHIFT and DONE. in_ready=(state==IDLE); out_valid=(state==DONE). Both are decoded from registered state only.
- IDLE, on in_valid: capture the operand, clear shamt/zero/ovf, then take the first matching case:
  - in_exp==255: pass through unchanged -> DONE.
  - in_carry=1: mant={1,in_mant[23:1]}, exp=in_exp+1 (in_exp 0 gives 1). If the new exp==255: mant=0, ovf=1 -> DONE.
  - in_mant==0: exp=0, zero=1 -> DONE.
  - in_mant[23]=1 or in_exp==0: unchanged -> DONE.
  - in_exp==1: exp=0 (subnormal), mant unchanged -> DONE.
  - Otherwise -> SHIFT.
- SHIFT, one step per cycle:
  - If exp==1: set exp=0, mant unchanged -> DONE.
  - Else: mant=mant<<1 (zero fill), exp=exp-1, shamt=shamt+1. Go to DONE if the old mant[22]==1, else stay in SHIFT.
- DONE: outputs held stable while out_valid=1 and out_ready=0. On out_ready=1 -> IDLE. No new accept in the same cycle (minimum 2-cycle spacing between accepts).
- Latency: accept edge T. out_valid rises after edge T+k, where k = SHIFT cycles:
  - k=0 for the pass-through, carry, zero and exp≤1 cases.
  - k=lz(in_mant) when not exponent-limited.
  - k=in_exp-1 shifts plus 1 underflow cycle when in_exp-1 < lz.
- Width rules: exp arithmetic is modulo 2^EW but never wraps, because of the guards above. out_shamt ≤ 23.
- Bits shifted out on the carry path are dropped; rounding and sticky handling are done downstream.

Test Plan:
- Reset asserted mid-SHIFT (in_mant=24'h000001, in_exp=100, 5 cycles in) -> out_valid=0 and in_ready=1 immediately; next operand processes normally.
- in_mant=24'h000001, in_exp=100, in_carry=0 -> after 23 SHIFT cycles: out_mant=24'h800000, out_exp=77, out_shamt=23, out_zero=0, out_ovf=0.
- in_mant=24'h000100, in_exp=5 -> 4 shifts plus 1 underflow cycle: out_mant=24'h001000, out_exp=0, out_shamt=4.
- in_carry=1, in_mant=24'h000003, in_exp=254 -> next cycle out_ovf=1, out_exp=255, out_mant=0. Same stimulus with in_exp=10 -> out_mant=24'h800001, out_exp=11, out_shamt=0.
- in_mant=0, in_exp=50 -> out_zero=1, out_exp=0. Then hold out_ready=0 for 6 cycles -> outputs stable, in_ready=0 throughout.
- Back-to-back in_valid with out_ready=1: in_mant=24'h400000/exp 3, then 24'h800000/exp 9 -> results (24'h800000, 2, shamt 1) then (24'h800000, 9, shamt 0), in order, none dropped.
